// File: rtl/pc_unit.sv
// Program-counter unit: PC/OldPC registers, four-way next-PC select, sticky misalignment flag.
// Define RAS_EN to add a circular return-address stack for call/return (PCSrc=11, Push).
module pc_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  ALIGN_BITS   = 2,
    parameter int                  INSTR_BYTES  = 4,
    parameter int                  RAS_DEPTH    = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PCWrite,
    input  logic                Branch,
    input  logic                Zero,
    input  logic [1:0]          PCSrc,
    input  logic [PC_WIDTH-1:0] ALUResult,
    input  logic [PC_WIDTH-1:0] ALUOut,
    input  logic [PC_WIDTH-1:0] JumpTarget,
    input  logic                IRWrite,
    input  logic                Push,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] OldPC,
    output logic [PC_WIDTH-1:0] PCNext,
    output logic                MisalignErr,
    output logic                RasOverflow,
    output logic                RasUnderflow
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;

    logic                pc_en;
    logic                misaligned;
    logic [PC_WIDTH-1:0] ret_addr;
    logic [PC_WIDTH-1:0] ras_top;

    assign pc_en      = PCWrite | (Branch & Zero);
    assign misaligned = |(PCNext & ~ALIGN_MASK);
    // Return address wraps modulo 2^PC_WIDTH.
    assign ret_addr   = OldPC + PC_WIDTH'(INSTR_BYTES);

`ifdef RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;
    logic [CNT_W-1:0]    ras_cnt;
    logic                ras_empty;
    logic                pop;
    logic                pop_hit;
    logic [PTR_W-1:0]    ptr_up;

    assign ras_empty = (ras_cnt == '0);
    assign pop       = pc_en & (PCSrc == 2'b11);
    assign pop_hit   = pop & ~ras_empty;
    assign ptr_up    = ras_ptr + PTR_W'(1);
    assign ras_top   = ras_empty ? ALUOut : ras_mem[ras_ptr];

    // Push during a real pop replaces the top; otherwise it writes one above.
    always_ff @(posedge CLK) begin
        if (Push) begin
            if (pop_hit) ras_mem[ras_ptr] <= ret_addr;
            else         ras_mem[ptr_up]  <= ret_addr;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ras_ptr      <= '0;
            ras_cnt      <= '0;
            RasOverflow  <= 1'b0;
            RasUnderflow <= 1'b0;
        end else if (pop_hit) begin
            if (!Push) begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end else begin
            if (pop) RasUnderflow <= 1'b1;
            if (Push) begin
                // Full stack: pointer wraps onto the oldest entry, count saturates.
                ras_ptr <= ptr_up;
                if (ras_cnt == RAS_FULL) RasOverflow <= 1'b1;
                else                     ras_cnt     <= ras_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign ras_top      = ALUOut;
    assign RasOverflow  = 1'b0;
    assign RasUnderflow = 1'b0;

    wire unused_ras = &{1'b0, Push, ret_addr, RAS_DEPTH[0]};
`endif

    always_comb begin
        PCNext = ALUResult;
        case (PCSrc)
            2'b00:   PCNext = ALUResult;
            2'b01:   PCNext = ALUOut;
            2'b10:   PCNext = JumpTarget;
            default: PCNext = ras_top;
        endcase
    end

    // OldPC captures the pre-update PC even when PC changes on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PC          <= RESET_VECTOR;
            OldPC       <= RESET_VECTOR;
            MisalignErr <= 1'b0;
        end else begin
            if (pc_en) begin
                PC <= PCNext & ALIGN_MASK;
                if (misaligned) MisalignErr <= 1'b1;
            end
            if (IRWrite) OldPC <= PC;
        end
    end

endmodule
